// File: rtl/imul_wb_queue_pkg.sv
// Shared types and constants for the multiply writeback queue.
// The FIFO entry tag field is sized by the package default tag width.
package imul_wb_queue_pkg;

    localparam int IMUL_RES_W = 65;
    localparam int IMUL_FLG_W = 6;
    localparam int IMUL_TAG_W = 9;

    typedef struct packed {
        logic [IMUL_TAG_W-1:0] tag;
        logic [IMUL_RES_W-1:0] res;
        logic [IMUL_FLG_W-1:0] flg;
        logic                  wflg;
    } wbq_entry_t;

endpackage

// File: rtl/imul_wb_queue_if.sv
// Writeback port bundle: valid/ready handshake plus head-entry payload.
interface imul_wb_queue_if
    import imul_wb_queue_pkg::*;
#(
    parameter int TAG_W = IMUL_TAG_W
) ();

    logic                  wb_valid;
    logic                  wb_ready;
    logic [TAG_W-1:0]      wb_tag;
    logic [IMUL_RES_W-1:0] wb_res;
    logic [IMUL_FLG_W-1:0] wb_flg;
    logic                  wb_flg_en;

    modport master (
        output wb_valid,
        output wb_tag,
        output wb_res,
        output wb_flg,
        output wb_flg_en,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_tag,
        input  wb_res,
        input  wb_flg,
        input  wb_flg_en,
        output wb_ready
    );

endinterface

// File: rtl/imul_lat_track.sv
// LAT-stage valid/tag shift register mirroring the multiply pipeline;
// advances only with clk_en and reports how many ops are in flight.
module imul_lat_track #(
    parameter int LAT   = 3,
    parameter int TAG_W = 9,
    localparam int IW   = $clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             iss_en,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic             iss_wflg,
    output logic             last_v,
    output logic [TAG_W-1:0] last_tag,
    output logic             last_wflg,
    output logic [IW-1:0]    inflight
);

    logic [LAT-1:0] v;
    logic [LAT-1:0] wflg;
    logic [TAG_W-1:0] tag [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (clk_en) begin
            v[0] <= iss_en;
            for (int i = 1; i < LAT; i++) v[i] <= v[i-1];
        end
    end

    // Payload needs no reset: it is only looked at when its valid bit is set.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            tag[0]  <= iss_tag;
            wflg[0] <= iss_wflg;
            for (int i = 1; i < LAT; i++) begin
                tag[i]  <= tag[i-1];
                wflg[i] <= wflg[i-1];
            end
        end
    end

    assign last_v    = v[LAT-1];
    assign last_tag  = tag[LAT-1];
    assign last_wflg = wflg[LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + IW'(v[i]);
    end

endmodule

// File: rtl/imul_wb_queue.sv
// Multiply-result writeback queue with issue credits.
// Optional: IMUL_WBQ_BYPASS_EN forwards a capture into an empty queue.
module imul_wb_queue
    import imul_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IMUL_TAG_W,
    parameter int LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clkEn,
    input  logic                  iss_en,
    input  logic [TAG_W-1:0]      iss_tag,
    input  logic                  iss_wflg,
    input  logic [IMUL_RES_W-1:0] mul_res,
    input  logic [IMUL_FLG_W-1:0] mul_flg,
    output logic                  iss_credit,
    imul_wb_queue_if.master       wb,
    output logic                  ovf_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = $clog2(DEPTH + LAT + 2);

    logic             last_v;
    logic             last_wflg;
    logic [TAG_W-1:0] last_tag;
    logic [IW-1:0]    inflight;

    imul_lat_track #(
        .LAT   (LAT),
        .TAG_W (TAG_W)
    ) u_track (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clkEn),
        .iss_en    (iss_en),
        .iss_tag   (iss_tag),
        .iss_wflg  (iss_wflg),
        .last_v    (last_v),
        .last_tag  (last_tag),
        .last_wflg (last_wflg),
        .inflight  (inflight)
    );

    wbq_entry_t    mem [DEPTH];
    wbq_entry_t    cap;
    wbq_entry_t    head;
    wbq_entry_t    out;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          wr;
    logic          empty;
    logic          full;
    logic          byp_take;
    logic [SW-1:0] demand;

    assign cap = '{
        tag:  IMUL_TAG_W'(last_tag),
        res:  mul_res,
        flg:  mul_flg,
        wflg: last_wflg
    };

    assign push  = clkEn && last_v;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr];

`ifdef IMUL_WBQ_BYPASS_EN
    assign byp_take = empty && push && wb.wb_ready;
`else
    assign byp_take = 1'b0;
`endif

    // When full, a pop frees the slot the simultaneous push lands in.
    assign pop = !empty && wb.wb_ready;
    assign wr  = push && !byp_take && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (wr && !pop)      count <= count + CW'(1);
            else if (!wr && pop) count <= count - CW'(1);
            if (push && full && !pop) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= cap;
    end

    always_comb begin
        wb.wb_valid = !empty;
        out         = empty ? '0 : head;
`ifdef IMUL_WBQ_BYPASS_EN
        if (empty && push) begin
            wb.wb_valid = 1'b1;
            out         = cap;
        end
`endif
        wb.wb_tag    = TAG_W'(out.tag);
        wb.wb_res    = out.res;
        wb.wb_flg    = out.flg;
        wb.wb_flg_en = out.wflg;
    end

    assign demand     = SW'(count) + SW'(inflight) + SW'(iss_en);
    assign iss_credit = demand < SW'(DEPTH);

endmodule

// File: tb/tb_imul_wb_queue.sv
// Bench for imul_wb_queue: latency table, scoreboarded writeback order,
// fill/full/overflow/reset sequences.
`timescale 1ns/1ps
module tb_imul_wb_queue;
    import imul_wb_queue_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 9;
`ifdef IMUL_WBQ_BYPASS_EN
    localparam int BASE = LAT;
`else
    localparam int BASE = LAT + 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rst_req = 1'b1;
    logic             clkEn = 1'b0;
    logic             iss_en = 1'b0;
    logic             iss_wflg = 1'b0;
    logic [TAG_W-1:0] iss_tag = '0;
    logic [64:0]      mul_res = '0;
    logic [5:0]       mul_flg = '0;
    logic             iss_credit;
    logic             ovf_err;

    imul_wb_queue_if #(.TAG_W(TAG_W)) wb_if ();

    imul_wb_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clkEn      (clkEn),
        .iss_en     (iss_en),
        .iss_tag    (iss_tag),
        .iss_wflg   (iss_wflg),
        .mul_res    (mul_res),
        .mul_flg    (mul_flg),
        .iss_credit (iss_credit),
        .wb         (wb_if),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [64:0]      res;
        logic [5:0]       flg;
        logic             wflg;
    } exp_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             wflg;
        int               stall;
        int               exp_lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t dummy;
    vec_t vt[4];
    int   ncmp = 0;
    int   nfail = 0;
    int   adv = 0;

    function automatic logic [64:0] res_of(input int n);
        logic [31:0] u;
        u = 32'(n);
        return {u[0], 32'h1000_0000 ^ u, 32'h2 + u};
    endfunction

    function automatic logic [5:0] flg_of(input int n);
        logic [31:0] u;
        u = 32'(n);
        return u[5:0] ^ 6'h2A;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        ncmp++;
        if (act !== want) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // The multiply unit is modelled by an advance counter: an op issued at
    // advance k emerges at advance k+LAT with res_of/flg_of(k+LAT).
    task automatic cyc(input logic ce, input logic ie,
                       input logic [TAG_W-1:0] tg, input logic wf,
                       input logic rdy);
        @(negedge clk);
        rst            = rst_req;
        clkEn          = ce;
        iss_en         = ie;
        iss_tag        = tg;
        iss_wflg       = wf;
        wb_if.wb_ready = rdy;
        mul_res        = res_of(adv);
        mul_flg        = flg_of(adv);
        if (ce && ie && !rst_req)
            exp_q.push_back('{tg, res_of(adv + LAT), flg_of(adv + LAT), wf});
        if (ce) adv++;
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic fill(input logic [TAG_W-1:0] base);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, base + TAG_W'(i), (i % 2) == 1, 1'b0);
            chk("fill_credit", iss_credit, i < 3);
        end
        idle(4, 1'b0);
        chk("fill_valid", wb_if.wb_valid, 1'b1);
        chk("fill_credit0", iss_credit, 1'b0);
        chk("fill_ovf", ovf_err, 1'b0);
        chk("fill_head", wb_if.wb_tag, base);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && wb_if.wb_valid && wb_if.wb_ready) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL sb_unexpected: got tag %0h want none",
                         wb_if.wb_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_tag", wb_if.wb_tag, mon_e.tag);
                chk("sb_res", wb_if.wb_res, mon_e.res);
                chk("sb_flg", wb_if.wb_flg, mon_e.flg);
                chk("sb_flg_en", wb_if.wb_flg_en, mon_e.wflg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic anyv;
        int   lat;

        vt[0] = '{9'h005, 1'b1, 0, BASE};
        vt[1] = '{9'h011, 1'b0, 5, BASE + 5};
        vt[2] = '{9'h1FF, 1'b1, 2, BASE + 2};
        vt[3] = '{9'h000, 1'b0, 1, BASE + 1};

        wb_if.wb_ready = 1'b0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_req = 1'b0;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_valid", wb_if.wb_valid, 1'b0);
        chk("rst_credit", iss_credit, 1'b1);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_tag", wb_if.wb_tag, 0);
        chk("rst_res", wb_if.wb_res, 0);
        chk("rst_flg", wb_if.wb_flg, 0);
        chk("rst_flg_en", wb_if.wb_flg_en, 1'b0);

        for (int k = 0; k < 4; k++) begin
            idle(3, 1'b1);
            cyc(1'b1, 1'b1, vt[k].tag, vt[k].wflg, 1'b1);
            seen = 1'b0;
            lat  = 0;
            for (int n = 1; n <= 40 && !seen; n++) begin
                cyc(n > vt[k].stall, 1'b0, '0, 1'b0, 1'b1);
                if (wb_if.wb_valid) begin
                    seen = 1'b1;
                    lat  = n;
                    chk("vec_tag", wb_if.wb_tag, vt[k].tag);
                    chk("vec_flg_en", wb_if.wb_flg_en, vt[k].wflg);
                end
            end
            chk("vec_latency", lat, vt[k].exp_lat);
        end
        idle(3, 1'b1);

        fill(9'h020);
        cyc(1'b1, 1'b1, 9'h044, 1'b1, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("full_cap_credit", iss_credit, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("full_ovf", ovf_err, 1'b0);
        chk("full_valid", wb_if.wb_valid, 1'b1);
        chk("full_head", wb_if.wb_tag, 9'h021);
        chk("full_credit", iss_credit, 1'b0);
        idle(4, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_valid", wb_if.wb_valid, 1'b0);
        chk("drain_credit", iss_credit, 1'b1);
        chk("drain_sb", exp_q.size(), 0);

        fill(9'h0A0);
        cyc(1'b1, 1'b1, 9'h0AF, 1'b1, 1'b0);
        dummy = exp_q.pop_back();
        idle(2, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_pre", ovf_err, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_set", ovf_err, 1'b1);
        idle(3, 1'b0);
        chk("ovf_sticky", ovf_err, 1'b1);
        chk("ovf_head", wb_if.wb_tag, 9'h0A0);
        idle(4, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_drained", wb_if.wb_valid, 1'b0);
        chk("ovf_hold", ovf_err, 1'b1);
        chk("ovf_sb", exp_q.size(), 0);

        cyc(1'b1, 1'b1, 9'h0B0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9'h0B1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9'h0B2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9'h0B3, 1'b1, 1'b0);
        chk("mid_valid", wb_if.wb_valid, 1'b1);
        rst_req = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        exp_q.delete();
        rst_req = 1'b0;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("mid_rst_valid", wb_if.wb_valid, 1'b0);
        chk("mid_rst_credit", iss_credit, 1'b1);
        chk("mid_rst_ovf", ovf_err, 1'b0);
        anyv = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
            anyv = anyv | wb_if.wb_valid;
        end
        chk("mid_rst_no_capture", anyv, 1'b0);
        chk("end_sb", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
